// File: rtl/mmio_bus_decoder.sv
// Memory-mapped bus controller: decodes CPU accesses into program/data RAM or NUM_IO handshaked I/O windows.
// Define MMIO_PROG_WRITE_EN to let writes reach program space (self-load) instead of raising a write-protect fault.

module mmio_bus_decoder #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [ADDR_W-1:0] PROG_TOP    = 16'h9FFF,
  parameter logic [ADDR_W-1:0] IO_BASE     = 16'hC000,
  parameter int unsigned       NUM_IO      = 4,
  parameter int unsigned       IO_SPAN_LG2 = 4,
  parameter int unsigned       TIMEOUT     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_adr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_adr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [NUM_IO-1:0]        io_sel,
  output logic                     io_we,
  output logic [IO_SPAN_LG2-1:0]   io_adr,
  output logic [DATA_W-1:0]        io_wdata,
  input  logic [NUM_IO*DATA_W-1:0] io_rdata,
  input  logic [NUM_IO-1:0]        io_ack,
  input  logic                     fault_clr,
  output logic                     fault,
  output logic [1:0]               fault_code,
  output logic [ADDR_W-1:0]        fault_adr
);

  // state  | meaning
  // IDLE   | waiting for cpu_req; decode and latch the request
  // MEM    | one-cycle RAM access (mem_en, mem_we)
  // MEM_RD | registered RAM read data arrives; capture it
  // IO     | hold io_sel/io_we until the window acks or the timer expires
  // RESP   | one-cycle cpu_ready pulse

  localparam int unsigned IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MEM, S_MEM_RD, S_IO, S_RESP} state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      adr_q;
  logic                   we_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [IDX_W-1:0]       io_idx;
  logic [IO_SPAN_LG2-1:0] io_off;
  logic [7:0]             tmo_cnt;

  logic [ADDR_W-1:0]      io_rel;
  logic [ADDR_W-1:0]      io_win;
  logic                   is_prog;
  logic                   is_mem;
  logic                   is_io;
  logic                   wrprot;
  logic                   io_hit;
  logic                   tmo_hit;
  logic                   flt_set;
  logic [1:0]             flt_code;
  logic [ADDR_W-1:0]      flt_adr;

  assign io_rel  = cpu_adr - IO_BASE;
  assign io_win  = io_rel >> IO_SPAN_LG2;
  assign is_prog = (cpu_adr <= PROG_TOP);
  assign is_mem  = is_prog || (cpu_adr < IO_BASE);
  assign is_io   = (cpu_adr >= IO_BASE) && (io_win < ADDR_W'(NUM_IO));

`ifdef MMIO_PROG_WRITE_EN
  assign wrprot = 1'b0;
`else
  assign wrprot = is_prog && cpu_we;
`endif

  assign io_hit  = io_ack[io_idx];
  // Down-counter loaded on entry to IO; the last waiting cycle is the one at count 1.
  assign tmo_hit = (state == S_IO) && !io_hit && (tmo_cnt <= 8'd1);

  assign mem_en    = (state == S_MEM);
  assign mem_we    = mem_en && we_q;
  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign io_we     = (state == S_IO) && we_q;
  assign io_adr    = io_off;
  assign io_wdata  = wdata_q;

  always_comb begin
    io_sel = '0;
    if (state == S_IO) io_sel[io_idx] = 1'b1;
  end

  always_comb begin
    flt_set  = 1'b0;
    flt_code = 2'b00;
    flt_adr  = cpu_adr;
    if (state == S_IDLE && cpu_req) begin
      if (wrprot) begin
        flt_set  = 1'b1;
        flt_code = 2'b01;
      end else if (!is_mem && !is_io) begin
        flt_set  = 1'b1;
        flt_code = 2'b10;
      end
    end
    if (tmo_hit) begin
      flt_set  = 1'b1;
      flt_code = 2'b11;
      flt_adr  = adr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      adr_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      io_idx     <= '0;
      io_off     <= '0;
      tmo_cnt    <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      fault_adr  <= '0;
    end else begin
      cpu_ready <= 1'b0;

      // A fault arriving with fault_clr is recorded rather than lost.
      if (flt_set && (!fault || fault_clr)) begin
        fault      <= 1'b1;
        fault_code <= flt_code;
        fault_adr  <= flt_adr;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= 2'b00;
        fault_adr  <= '0;
      end

      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            adr_q   <= cpu_adr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            io_idx  <= io_win[IDX_W-1:0];
            io_off  <= io_rel[IO_SPAN_LG2-1:0];
            if (wrprot || (!is_mem && !is_io)) begin
              cpu_rdata <= '0;
              cpu_ready <= 1'b1;
              state     <= S_RESP;
            end else if (is_mem) begin
              state <= S_MEM;
            end else begin
              tmo_cnt <= 8'(TIMEOUT);
              state   <= S_IO;
            end
          end
        end
        S_MEM: begin
          if (we_q) begin
            cpu_ready <= 1'b1;
            state     <= S_RESP;
          end else begin
            state <= S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          cpu_rdata <= mem_rdata;
          cpu_ready <= 1'b1;
          state     <= S_RESP;
        end
        S_IO: begin
          if (io_hit) begin
            if (!we_q) cpu_rdata <= io_rdata[DATA_W*int'(io_idx) +: DATA_W];
            tmo_cnt   <= '0;
            cpu_ready <= 1'b1;
            state     <= S_RESP;
          end else if (tmo_hit) begin
            cpu_rdata <= '0;
            tmo_cnt   <= '0;
            cpu_ready <= 1'b1;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Self-checking bench for mmio_bus_decoder: table of single transactions plus hand-written
// sequences for fault stickiness, clear/set collision and reset during an I/O wait.

module tb_mmio_bus_decoder;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_adr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_adr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [3:0]  io_sel;
  logic        io_we;
  logic [3:0]  io_adr;
  logic [15:0] io_wdata;
  logic [63:0] io_rdata;
  logic [3:0]  io_ack;
  logic        fault_clr;
  logic        fault;
  logic [1:0]  fault_code;
  logic [15:0] fault_adr;

  mmio_bus_decoder dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_sel(io_sel), .io_we(io_we), .io_adr(io_adr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack),
    .fault_clr(fault_clr), .fault(fault), .fault_code(fault_code), .fault_adr(fault_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] wdata;
    logic [15:0] ram;
    int          ack_at;   // IO cycle carrying the ack, 0 = never
    int          win;
    logic [15:0] io_val;
    bit          noise;    // pulse io_ack[0] before the real ack
    int          rdy;
    bit          chk_rd;
    logic [15:0] rd;
    bit          flt;
    logic [1:0]  code;
    int          mem_cnt;
    bit          mwe;
    logic [3:0]  sel;
    logic [3:0]  ioadr;
    int          iocyc;
    bit          iowe;
  } vec_t;

  vec_t vecs[12];

  int checks = 0;
  int errors = 0;

  int          o_rdy;
  int          o_mem;
  int          o_iocyc;
  bit          o_mwe;
  bit          o_iowe;
  bit          o_pulse;
  logic [3:0]  o_sel;
  logic [3:0]  o_ioadr;
  logic [15:0] o_madr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the ready cycle.
  task automatic run_txn(input logic we, input logic [15:0] adr, input logic [15:0] wdata,
                         input logic [15:0] ram, input int ack_at, input int win,
                         input logic [15:0] io_val, input bit noise, input bit clr);
    bit ram_flag;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_adr   = adr;
    cpu_wdata = wdata;
    fault_clr = clr;
    io_ack    = 4'b0;
    mem_rdata = 16'hDEAD;
    for (int i = 0; i < 4; i++)
      io_rdata[i*16 +: 16] = (i == win) ? io_val : (16'h5A00 + 16'(i));
    o_rdy = -1; o_mem = 0; o_iocyc = 0; o_mwe = 0; o_iowe = 0; o_pulse = 0;
    o_sel = 4'b0; o_ioadr = 4'b0; o_madr = 16'h0;
    ram_flag = 0;
    for (int n = 1; n <= 40 && o_rdy < 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      cpu_req   = 1'b0;
      fault_clr = 1'b0;
      io_ack    = 4'b0;
      mem_rdata = ram_flag ? ram : 16'hDEAD;
      ram_flag  = 0;
      if (mem_en) begin
        o_mem++;
        o_madr = mem_adr;
        if (mem_we) o_mwe = 1;
        ram_flag = 1;
      end
      if (io_sel != 4'b0) begin
        o_iocyc++;
        o_sel   = o_sel | io_sel;
        o_ioadr = io_adr;
        if (io_we) o_iowe = 1;
        if (o_iocyc == ack_at) io_ack[win] = 1'b1;
        else if (noise && o_iocyc < ack_at) io_ack[0] = 1'b1;
      end
      if (cpu_ready) o_rdy = n;
    end
    if (o_rdy > 0) begin
      @(posedge clk);
      @(negedge clk);
      o_pulse   = cpu_ready;
      mem_rdata = 16'hDEAD;
    end
  endtask

  initial begin
    // we adr wdata ram ack_at win io_val noise | rdy chk_rd rd flt code mem_cnt mwe sel ioadr iocyc iowe
    vecs[0]  = '{1'b0, 16'hA000, 16'h0000, 16'h1234, 0, 0, 16'h0000, 1'b0, 3, 1'b1, 16'h1234, 1'b0, 2'b00, 1, 1'b0, 4'b0000, 4'h0, 0, 1'b0};
    vecs[1]  = '{1'b1, 16'hA002, 16'h5555, 16'h0000, 0, 0, 16'h0000, 1'b0, 2, 1'b0, 16'h0000, 1'b0, 2'b00, 1, 1'b1, 4'b0000, 4'h0, 0, 1'b0};
    vecs[2]  = '{1'b0, 16'h0100, 16'h0000, 16'h4321, 0, 0, 16'h0000, 1'b0, 3, 1'b1, 16'h4321, 1'b0, 2'b00, 1, 1'b0, 4'b0000, 4'h0, 0, 1'b0};
`ifdef MMIO_PROG_WRITE_EN
    vecs[3]  = '{1'b1, 16'h0010, 16'h0AAA, 16'h0000, 0, 0, 16'h0000, 1'b0, 2, 1'b0, 16'h0000, 1'b0, 2'b00, 1, 1'b1, 4'b0000, 4'h0, 0, 1'b0};
`else
    vecs[3]  = '{1'b1, 16'h0010, 16'h0AAA, 16'h0000, 0, 0, 16'h0000, 1'b0, 1, 1'b0, 16'h0000, 1'b1, 2'b01, 0, 1'b0, 4'b0000, 4'h0, 0, 1'b0};
`endif
    vecs[4]  = '{1'b0, 16'hC012, 16'h0000, 16'h0000, 3, 1, 16'hBEEF, 1'b1, 4, 1'b1, 16'hBEEF, 1'b0, 2'b00, 0, 1'b0, 4'b0010, 4'h2, 3, 1'b0};
    vecs[5]  = '{1'b1, 16'hC005, 16'h6060, 16'h0000, 1, 0, 16'h0000, 1'b0, 2, 1'b0, 16'h0000, 1'b0, 2'b00, 0, 1'b0, 4'b0001, 4'h5, 1, 1'b1};
    vecs[6]  = '{1'b0, 16'hC030, 16'h0000, 16'h0000, 0, 3, 16'h1111, 1'b0, 16, 1'b1, 16'h0000, 1'b1, 2'b11, 0, 1'b0, 4'b1000, 4'h0, 15, 1'b0};
    vecs[7]  = '{1'b0, 16'hC040, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1'b0, 1, 1'b1, 16'h0000, 1'b1, 2'b10, 0, 1'b0, 4'b0000, 4'h0, 0, 1'b0};
    vecs[8]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1'b0, 1, 1'b1, 16'h0000, 1'b1, 2'b10, 0, 1'b0, 4'b0000, 4'h0, 0, 1'b0};
    vecs[9]  = '{1'b0, 16'h9FFF, 16'h0000, 16'h0909, 0, 0, 16'h0000, 1'b0, 3, 1'b1, 16'h0909, 1'b0, 2'b00, 1, 1'b0, 4'b0000, 4'h0, 0, 1'b0};
    vecs[10] = '{1'b0, 16'hBFFF, 16'h0000, 16'h0B0B, 0, 0, 16'h0000, 1'b0, 3, 1'b1, 16'h0B0B, 1'b0, 2'b00, 1, 1'b0, 4'b0000, 4'h0, 0, 1'b0};
    vecs[11] = '{1'b0, 16'hC03F, 16'h0000, 16'h0000, 1, 3, 16'h7777, 1'b0, 2, 1'b1, 16'h7777, 1'b0, 2'b00, 0, 1'b0, 4'b1000, 4'hF, 1, 1'b0};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = 16'h0; cpu_wdata = 16'h0;
    mem_rdata = 16'hDEAD; io_rdata = 64'h0; io_ack = 4'b0; fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cpu_rdata", cpu_rdata, 16'h0);
    chk("reset cpu_ready", cpu_ready, 1'b0);
    chk("reset fault", fault, 1'b0);
    chk("reset fault_code", fault_code, 2'b00);
    chk("reset fault_adr", fault_adr, 16'h0);
    chk("reset mem_en", mem_en, 1'b0);
    chk("reset io_sel", io_sel, 4'b0);
    chk("reset io_we", io_we, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      logic [15:0] efa;
      fault_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fault_clr = 1'b0;
      chk($sformatf("v%0d fault cleared", i), fault, 1'b0);
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].ram, vecs[i].ack_at,
              vecs[i].win, vecs[i].io_val, vecs[i].noise, 1'b0);
      efa = vecs[i].flt ? vecs[i].adr : 16'h0;
      chk($sformatf("v%0d ready cycle", i), o_rdy, vecs[i].rdy);
      if (vecs[i].chk_rd) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].rd);
      chk($sformatf("v%0d fault", i), fault, vecs[i].flt);
      chk($sformatf("v%0d fault_code", i), fault_code, vecs[i].code);
      chk($sformatf("v%0d fault_adr", i), fault_adr, efa);
      chk($sformatf("v%0d mem_en cycles", i), o_mem, vecs[i].mem_cnt);
      if (vecs[i].mem_cnt > 0) chk($sformatf("v%0d mem_adr", i), o_madr, vecs[i].adr);
      chk($sformatf("v%0d mem_we", i), o_mwe, vecs[i].mwe);
      chk($sformatf("v%0d io_sel", i), o_sel, vecs[i].sel);
      chk($sformatf("v%0d io_adr", i), o_ioadr, vecs[i].ioadr);
      chk($sformatf("v%0d io cycles", i), o_iocyc, vecs[i].iocyc);
      chk($sformatf("v%0d io_we", i), o_iowe, vecs[i].iowe);
      chk($sformatf("v%0d ready pulse width", i), o_pulse, 1'b0);
    end

    // Sticky first fault, then clear colliding with a new fault.
    fault_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fault_clr = 1'b0;
    run_txn(1'b0, 16'hC020, 16'h0, 16'h0, 0, 2, 16'h2222, 1'b0, 1'b0);
    chk("sticky timeout ready", o_rdy, 16);
    chk("sticky first code", fault_code, 2'b11);
    chk("sticky first adr", fault_adr, 16'hC020);
    run_txn(1'b0, 16'hC040, 16'h0, 16'h0, 0, 0, 16'h0, 1'b0, 1'b0);
    chk("sticky second fault", fault, 1'b1);
    chk("sticky second code kept", fault_code, 2'b11);
    chk("sticky second adr kept", fault_adr, 16'hC020);
    run_txn(1'b0, 16'hC050, 16'h0, 16'h0, 0, 0, 16'h0, 1'b0, 1'b1);
    chk("clr+set fault", fault, 1'b1);
    chk("clr+set code", fault_code, 2'b10);
    chk("clr+set adr", fault_adr, 16'hC050);
    run_txn(1'b0, 16'hA000, 16'h0, 16'h4242, 0, 0, 16'h0, 1'b0, 1'b0);
    chk("pre-reset read data", cpu_rdata, 16'h4242);
    chk("pre-reset fault held", fault, 1'b1);

    // Reset in the middle of an I/O wait.
    begin
      int rdy_seen;
      rdy_seen = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'hC020; io_ack = 4'b0;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      repeat (4) begin
        if (cpu_ready) rdy_seen++;
        @(negedge clk);
      end
      chk("mid-io io_sel", io_sel, 4'b0100);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort io_sel", io_sel, 4'b0);
      chk("abort io_we", io_we, 1'b0);
      chk("abort mem_en", mem_en, 1'b0);
      chk("abort cpu_rdata", cpu_rdata, 16'h0);
      chk("abort fault", fault, 1'b0);
      chk("abort fault_code", fault_code, 2'b00);
      chk("abort fault_adr", fault_adr, 16'h0);
      for (int c = 0; c < 20; c++) begin
        if (cpu_ready) rdy_seen++;
        @(negedge clk);
      end
      chk("abort no ready", rdy_seen, 0);
    end
    run_txn(1'b0, 16'hA000, 16'h0, 16'h1234, 0, 0, 16'h0, 1'b0, 1'b0);
    chk("post-reset ready cycle", o_rdy, 3);
    chk("post-reset cpu_rdata", cpu_rdata, 16'h1234);
    chk("post-reset mem_en cycles", o_mem, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_bus_decoder.md
Name: mmio_bus_decoder

Overview:
- Parametrised memory-mapped bus controller between the CPU datapath and its memory and peripherals.
- Replaces the single-enable address range check with a full address decoder:
  - program, data and I/O windows set by parameters;
  - NUM_IO peripheral windows, each with an ack/wait handshake;
  - a write-protect on program space;
  - a sticky fault status register.
- Sits between statemachine/dataPath and exmem/peripherals (vga, controllers, RNG); one transaction in flight at a time.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- PROG_TOP, 16'h9FFF, last program-space address (inclusive)
- IO_BASE, 16'hC000, first I/O address
- NUM_IO, 4, number of I/O windows
- IO_SPAN_LG2, 4, log2 of words per I/O window
- TIMEOUT, 15, max I/O cycles waiting for ack (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  transaction request, sampled in IDLE only
- cpu_we  in  1  1 = write, 0 = read
- cpu_adr  in  ADDR_W  transaction address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data; holds until next completion
- cpu_ready  out  1  one-cycle completion pulse
- mem_en  out  1  RAM enable, one cycle per access
- mem_we  out  1  RAM write strobe
- mem_adr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, registered (valid the cycle after mem_en)
- io_sel  out  NUM_IO  one-hot window select
- io_we  out  1  I/O write strobe
- io_adr  out  IO_SPAN_LG2  offset within window
- io_wdata  out  DATA_W  I/O write data
- io_rdata  in  NUM_IO*DATA_W  per-window read data; window k in slice k
- io_ack  in  NUM_IO  per-window completion
- fault_clr  in  1  clears fault status
- fault  out  1  sticky fault flag
- fault_code  out  2  01 write-protect, 10 unmapped, 11 I/O timeout
- fault_adr  out  ADDR_W  address of the first fault

Behaviour:
- Address classes:
  - PROG: adr <= PROG_TOP
  - DATA: PROG_TOP < adr < IO_BASE
  - IO window k: k = (adr-IO_BASE)>>IO_SPAN_LG2, when k < NUM_IO
  - all other addresses are UNMAPPED
- FSM states: IDLE, MEM, MEM_RD, IO, RESP. Outputs decode from registered state and latched request.
- IDLE, cpu_req=1 at an edge: latch adr/we/wdata, then branch:
  - PROG write -> RESP, WRPROT fault, no mem_we.
  - UNMAPPED -> RESP, UNMAPPED fault, cpu_rdata=0.
  - PROG/DATA -> MEM.
  - IO -> IO.
- MEM: mem_en=1 and mem_we=latched we for exactly one cycle.
  - write -> RESP
  - read -> MEM_RD
- MEM_RD: cpu_rdata <= mem_rdata at end of cycle -> RESP.
- IO:
  - io_sel[k]=1 and io_we held every IO cycle.
  - io_ack[k]=1 in a cycle -> capture slice k (reads) and go to RESP.
  - Acks on other windows are ignored.
  - An 8-bit counter counts IO cycles. TIMEOUT cycles without ack -> RESP, TIMEOUT fault, cpu_rdata=0.
- RESP: cpu_ready=1 for one cycle -> IDLE. cpu_req during RESP is ignored.
- Latency, request-cycle edge = cycle 0:
  - memory write: ready in cycle 2
  - memory read: ready in cycle 3
  - I/O with ack in its first IO cycle: ready in cycle 2
  - fault without access: ready in cycle 1
- Fault register:
  - Set on any fault only when fault=0, so the first fault's code and address are kept.
  - fault_clr clears it.
  - fault_clr and a new fault in the same cycle -> the new fault is recorded (set wins).
- Reset: at the edge with rst=1, state=IDLE and every output register is 0 (cpu_rdata, cpu_ready, fault, fault_code, fault_adr, timeout counter). mem_en, io_sel and io_we are deasserted in the next cycle.
- Reset mid-transaction aborts the access with no cpu_ready pulse.
- Address arithmetic is unsigned, ADDR_W bits, with no wrap; adr=all-ones is valid only if it falls in a window.

Optional Feature:
- MMIO_PROG_WRITE_EN
  - Defined: writes to PROG behave as DATA writes (bootloader/self-load); no WRPROT fault.
  - Undefined: PROG writes are blocked and flagged with code 01.

Test Plan:
- Read DATA 16'hA000, RAM returns 16'h1234 the cycle after mem_en -> mem_en one cycle, ready in cycle 3, cpu_rdata=16'h1234, fault=0.
- Write PROG 16'h0010 (macro undefined) -> no mem_en/mem_we, ready in cycle 1, fault=1, code=01, fault_adr=16'h0010. Same with macro defined -> mem_we=1, fault=0.
- Read 16'hC012 (window 1, offset 2), io_ack[1] after 3 IO cycles, slice 1=16'hBEEF -> io_sel=4'b0010, io_adr=2, cpu_rdata=16'hBEEF. io_ack[0] pulses beforehand are ignored.
- Read 16'hC030 with no ack -> io_sel[3] held for 15 cycles, then ready, cpu_rdata=0, code=11.
- Access 16'hC040 -> UNMAPPED, code=10. A second fault does not overwrite code or address. fault_clr together with a new fault -> fault stays 1 with the new code.
- rst asserted during IO wait -> no ready, io_sel=0 next cycle, all outputs 0. Next request completes normally.
